// File: rtl/csa_stream_accum.sv
// Streaming carry-save accumulator: folds three operands per beat into a redundant
// (sum, carry) pair and resolves it with one carry-propagate add at packet end.
module csa_stream_accum #(
  parameter int WIDTH = 4,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_ovf
);

  localparam logic [1:0] ACCUM   = 2'd0;
  localparam logic [1:0] RESOLVE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  function automatic logic [ACC_W-1:0] csa_sum(input logic [ACC_W-1:0] x,
                                               input logic [ACC_W-1:0] y,
                                               input logic [ACC_W-1:0] z);
    return x ^ y ^ z;
  endfunction

  function automatic logic [ACC_W-1:0] csa_carry(input logic [ACC_W-1:0] x,
                                                 input logic [ACC_W-1:0] y,
                                                 input logic [ACC_W-1:0] z);
    return (x & y) | (z & (x ^ y));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [1:0]       state;
  logic             vld_p0;
  logic             last_p0;
  logic [ACC_W-1:0] a_p0, b_p0, c_p0;
  logic [ACC_W-1:0] acc_s, acc_c;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic [ACC_W-1:0] s1, k1, s2, k2, s3, k3;
  logic             fold_ovf;
  logic [ACC_W:0]   total;
  logic             take;

  // Stall input while the last beat is still waiting to be folded in.
  assign in_ready = rst_n & (state == ACCUM) & ~(vld_p0 & last_p0);
  assign take     = in_valid & in_ready;

  // p0: register operands, zero-extended to accumulator width
  always_ff @(posedge clk) begin
    if (take) begin
      a_p0 <= ACC_W'(in_a);
      b_p0 <= ACC_W'(in_b);
      c_p0 <= ACC_W'(in_c);
    end
  end

  // p1: three chained 3:2 compressors; every carry MSB shifted out is a lost 2^ACC_W
  assign s1 = csa_sum(a_p0, b_p0, c_p0);
  assign k1 = csa_carry(a_p0, b_p0, c_p0);
  assign s2 = csa_sum(s1, k1 << 1, acc_s);
  assign k2 = csa_carry(s1, k1 << 1, acc_s);
  assign s3 = csa_sum(s2, k2 << 1, acc_c);
  assign k3 = csa_carry(s2, k2 << 1, acc_c);
  assign fold_ovf = k1[ACC_W-1] | k2[ACC_W-1] | k3[ACC_W-1];
  assign total    = {1'b0, acc_s} + {1'b0, acc_c};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      vld_p0    <= 1'b0;
      last_p0   <= 1'b0;
      acc_s     <= '0;
      acc_c     <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_sum   <= '0;
      out_beats <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      vld_p0 <= take;
      if (take) last_p0 <= in_last;
      case (state)
        ACCUM: begin
          if (vld_p0) begin
            acc_s <= s3;
            acc_c <= k3 << 1;
            cnt   <= sat_inc(cnt);
            ovf   <= ovf | fold_ovf;
            if (last_p0) state <= RESOLVE;
          end
        end
        RESOLVE: begin
          out_sum   <= total[ACC_W-1:0];
          out_ovf   <= ovf | total[ACC_W];
          out_beats <= cnt;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            acc_s     <= '0;
            acc_c     <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_stream_accum.sv
// Bench for csa_stream_accum: directed packets plus random packets, checked by a
// queue-based scoreboard fed from an integer reference of each packet's total.
module tb_csa_stream_accum;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = '0, in_b = '0, in_c = '0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_sum;
  logic [3:0] out_beats;
  logic       out_ovf;

  typedef struct { int sum; int beats; int ovf; } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad = 0;
  int pkt_total = 0;
  int pkt_n = 0;
  bit rnd_mode = 0;

  csa_stream_accum #(.WIDTH(4), .ACC_W(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_beats(out_beats), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, req, $time);
    end
  endtask

  // Scoreboard monitor: a result is consumed at the edge following a negedge
  // where out_valid & out_ready are both high.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result sum=%0d beats=%0d", out_sum, out_beats);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_sum", int'(out_sum), e.sum);
        chk("out_beats", int'(out_beats), e.beats);
        chk("out_ovf", int'(out_ovf), e.ovf);
      end
    end
  end

  task automatic rnd_ready();
    if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic beat(input int a, input int b, input int c, input bit last);
    int waitc;
    bit done;
    waitc = 0;
    done = 0;
    in_valid = 1'b1;
    in_a = 4'(a);
    in_b = 4'(b);
    in_c = 4'(c);
    in_last = last;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end else begin
        @(posedge clk);
        #1;
        rnd_ready();
        waitc++;
        if (waitc > 300) begin
          chk("beat_accept_timeout", 0, 1);
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
    pkt_total += a + b + c;
    pkt_n++;
    if (last) begin
      exp_q.push_back('{pkt_total % 256, (pkt_n > 15) ? 15 : pkt_n,
                        (pkt_total >= 256) ? 1 : 0});
      pkt_total = 0;
      pkt_n = 0;
    end
    rnd_ready();
  endtask

  task automatic packet(input int n, input int v);
    for (int i = 0; i < n; i++) beat(v, v, v, i == n - 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #10;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sum", int'(out_sum), 0);
    chk("rst_out_beats", int'(out_beats), 0);
    chk("rst_out_ovf", int'(out_ovf), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk("rel_in_ready", int'(in_ready), 1);

    // single beat with latency check
    beat(3, 5, 7, 1);
    @(posedge clk); #1;
    chk("lat_edge1_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    chk("lat_edge2_valid", int'(out_valid), 1);
    wait_drain();

    packet(4, 15);
    wait_drain();
    packet(6, 15);
    wait_drain();

    // asynchronous reset mid-packet, outputs still holding the 270-total result
    beat(15, 15, 15, 0);
    beat(15, 15, 15, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_sum", int'(out_sum), 0);
    chk("arst_out_beats", int'(out_beats), 0);
    chk("arst_out_ovf", int'(out_ovf), 0);
    chk("arst_in_ready", int'(in_ready), 0);
    pkt_total = 0;
    pkt_n = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk("arst_rel_ready", int'(in_ready), 1);
    beat(1, 1, 1, 1);
    wait_drain();

    // backpressure: result held, input stalled, stray beats ignored
    out_ready = 1'b0;
    packet(4, 15);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    chk("hold_valid_seen", int'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_a = 4'd15; in_b = 4'd15; in_c = 4'd15; in_last = 1'b1;
      @(negedge clk);
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_sum", int'(out_sum), 180);
      chk("hold_beats", int'(out_beats), 4);
      chk("hold_ovf", int'(out_ovf), 0);
      chk("hold_in_ready", int'(in_ready), 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    beat(1, 2, 0, 1);
    wait_drain();

    packet(20, 0);
    wait_drain();

    // random packets with idle gaps and random output backpressure
    rnd_mode = 1;
    for (int p = 0; p < 12; p++) begin
      int n;
      n = $urandom_range(1, 20);
      for (int j = 0; j < n; j++) begin
        int idle;
        idle = $urandom_range(0, 2);
        for (int k = 0; k < idle; k++) begin
          @(posedge clk); #1;
          rnd_ready();
        end
        beat($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), j == n - 1);
      end
    end
    rnd_mode = 0;
    out_ready = 1'b1;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csa_stream_accum.md
Name: csa_stream_accum

Overview:
- Parametrised streaming carry-save accumulator; successor to the fixed 4-bit three-operand carry-save adder.
- Accepts three WIDTH-bit operands per beat over a valid/ready stream.
- Folds each beat into a redundant (sum, carry) accumulator with no carry propagation per beat.
- On the packet's last beat, resolves the total with a single carry-propagate add and presents it on an output valid/ready port, with beat count and overflow flag. Sits between operand producers and downstream result consumers.

Parameters:
- WIDTH, 4: operand width; must be 1 ≤ WIDTH ≤ ACC_W.
- ACC_W, 16: accumulator and result width; arithmetic is mod 2^ACC_W.
- CNT_W, 8: beat-counter width.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: operand beat valid.
- in_ready, output, 1: block accepts a beat.
- in_a, input, WIDTH: operand a.
- in_b, input, WIDTH: operand b.
- in_c, input, WIDTH: operand c.
- in_last, input, 1: beat is the packet's final beat.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts result.
- out_sum, output, ACC_W: resolved packet sum mod 2^ACC_W.
- out_beats, output, CNT_W: beats accepted in packet, saturating.
- out_ovf, output, 1: true packet sum ≥ 2^ACC_W.

Behaviour:
- Reset is asynchronous, active-low, and applies at any time, including mid-packet or mid-output. It clears: acc_s, acc_c, beat counter, sticky ovf, out_sum, out_beats, out_ovf, out_valid. State returns to ACCUM. in_ready=0 while rst_n low and 1 in the first cycle after release. No partial packet survives reset.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - RESOLVE: in_ready=0, out_valid=0, one cycle.
  - DONE: in_ready=0, out_valid=1.
- Beat accept: in_valid & in_ready at a rising edge. Operands are zero-extended to ACC_W.
- Compression per accepted beat uses three chained 3:2 stages, each bit computed as sum=x^y^z, carry=(x&y)|(z&(x^y)):
  - Stage 1: (a, b, c) → (s1, k1).
  - Stage 2: (s1, k1<<1, acc_s) → (s2, k2).
  - Stage 3: (s2, k2<<1, acc_c) → (s3, k3).
  - acc_s ← s3; acc_c ← k3<<1. All values are truncated to ACC_W.
- Sticky ovf is set if bit ACC_W-1 of k1, k2 or k3 is 1 on any accepted beat; each such bit is a dropped 2^ACC_W.
- Beat counter increments per accepted beat and saturates at 2^CNT_W-1.
- ACCUM→RESOLVE when an accepted beat has in_last=1; that beat is included in the total.
- RESOLVE: acc_s+acc_c is computed as an (ACC_W+1)-bit add.
  - out_sum ← low ACC_W bits.
  - out_ovf ← sticky ovf | carry-out.
  - out_beats ← counter.
  - Go to DONE.
- Latency: last beat accepted at edge T → out_valid=1 after edge T+2.
- DONE:
  - out_sum, out_beats and out_ovf are held stable while out_valid & !out_ready.
  - On out_valid & out_ready: clear acc_s, acc_c, counter and sticky ovf; out_valid←0; go to ACCUM. in_ready=1 in the next cycle.
- in_valid while in_ready=0 is ignored; the producer must hold the beat. No beat is lost or double-counted.
- A packet of exactly one beat (in_last on the first beat) is legal.
- out_sum, out_beats and out_ovf hold their last values after handshake until the next RESOLVE.

Test Plan (WIDTH=4, ACC_W=8, CNT_W=4):
- Single beat a=3, b=5, c=7, last=1 → out_valid two edges later, out_sum=15, out_beats=1, out_ovf=0.
- Four beats of a=b=c=15, last on 4th → out_sum=180, out_beats=4, out_ovf=0; check acc_s+acc_c=45·n after each beat.
- Six beats of a=b=c=15 (total 270) → out_sum=14, out_ovf=1.
- Same packet as the four-beat case with out_ready held low 5 cycles → output stable, in_ready=0, in_valid pulses ignored. Then out_ready=1 → next packet a=1, b=2, c=0 single beat → out_sum=3, out_beats=1.
- Twenty beats of zeros, last on 20th → out_sum=0, out_beats=15 (saturated), out_ovf=0.
- Reset asserted asynchronously after 2 beats of 15s → all outputs 0 immediately. After release, single beat 1, 1, 1 → out_sum=3, out_beats=1, out_ovf=0.
